// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults.
// Redirect kinds are listed in PC-update priority order.
package fetch_pkg;

   localparam int          DEF_HART_NUM = 4;
   localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0013;

   // Highest priority first: flush, branch, hart start, sequential
   typedef enum logic [2:0] {
      RD_NONE,
      RD_FLUSH,
      RD_BRANCH,
      RD_START,
      RD_SEQ
   } redir_e;

   function automatic int hart_id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hart_rr_arbiter.sv
// Round-robin hart picker: first active hart at or above ptr.
// Falls back to ptr when no hart is active.
module hart_rr_arbiter
   import fetch_pkg::*;
#(
   parameter int HART_NUM  = DEF_HART_NUM,
   parameter int HART_ID_W = hart_id_w(HART_NUM)
) (
   input  logic [HART_NUM-1:0]  hart_active,
   input  logic [HART_ID_W-1:0] rr_ptr,
   output logic [HART_ID_W-1:0] sel,
   output logic                 any_act
);

   // Scan downward so the closest hart to rr_ptr is written last
   always_comb begin
      logic [HART_ID_W-1:0] idx;
      idx     = rr_ptr;
      sel     = rr_ptr;
      any_act = |hart_active;
      for (int i = HART_NUM - 1; i >= 0; i--) begin
         idx = HART_ID_W'((int'(rr_ptr) + i) % HART_NUM);
         if (hart_active[idx])
            sel = idx;
      end
   end

endmodule

// File: rtl/mt_fetch_reg.sv
// Multithreaded fetch stage with per-hart PCs and IF/ID register.
// Round-robin hart select, priority redirects, ready handshake.
module mt_fetch_reg
   import fetch_pkg::*;
#(
   parameter int                HART_NUM  = DEF_HART_NUM,
   parameter int                ADDR_W    = 32,
   parameter int                INSN_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [INSN_W-1:0] NOP_INSN  = INSN_W'(DEF_NOP_INSN),
   localparam int               HART_ID_W = hart_id_w(HART_NUM)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [HART_NUM-1:0]  hart_active,
   input  logic                 hs_valid,
   input  logic [HART_ID_W-1:0] hs_id,
   input  logic [ADDR_W-1:0]    hs_pc,
   input  logic                 br_taken,
   input  logic [HART_ID_W-1:0] br_hart_id,
   input  logic [ADDR_W-1:0]    br_addr,
   input  logic                 flush,
   input  logic [HART_ID_W-1:0] flush_hart_id,
   input  logic [ADDR_W-1:0]    flush_pc,
   input  logic                 stall,
   output logic                 imem_req,
   output logic [ADDR_W-1:0]    imem_addr,
   input  logic                 imem_rdy,
   input  logic [INSN_W-1:0]    imem_insn,
   output logic [ADDR_W-1:0]    if_pc,
   output logic [INSN_W-1:0]    if_insn,
   output logic                 if_en,
   output logic [HART_ID_W-1:0] if_hart_id
);

   localparam logic [HART_ID_W-1:0] LAST_HART = HART_ID_W'(HART_NUM - 1);

   logic [ADDR_W-1:0]    pcs    [HART_NUM];
   logic [ADDR_W-1:0]    pc_nxt [HART_NUM];
   redir_e               redir  [HART_NUM];
   logic [HART_ID_W-1:0] rr_ptr;
   logic [HART_ID_W-1:0] sel;
   logic                 any_act;
   logic                 fire;
   logic                 squash;
   logic                 flush_if;
   logic                 br_if;
   logic                 do_bubble;
   logic                 do_load;

   hart_rr_arbiter #(
      .HART_NUM  (HART_NUM),
      .HART_ID_W (HART_ID_W)
   ) u_arb (
      .hart_active (hart_active),
      .rr_ptr      (rr_ptr),
      .sel         (sel),
      .any_act     (any_act)
   );

   assign imem_req  = any_act & ~stall;
   assign imem_addr = pcs[sel];
   assign fire      = imem_req & imem_rdy;
   assign squash    = fire & ((br_taken & (br_hart_id == sel)) |
                              (flush & (flush_hart_id == sel)));

   assign flush_if  = flush & (flush_hart_id == if_hart_id);
   assign br_if     = br_taken & (br_hart_id == if_hart_id);
   assign do_bubble = flush_if | (~stall & (br_if | ~fire | squash));
   assign do_load   = ~do_bubble & ~stall;

   // Pick the winning redirect source for each hart
   always_comb begin
      for (int h = 0; h < HART_NUM; h++) begin
         redir[h] = RD_NONE;
         priority case (1'b1)
            flush && (flush_hart_id == HART_ID_W'(h)):
               redir[h] = RD_FLUSH;
            br_taken && !stall && (br_hart_id == HART_ID_W'(h)):
               redir[h] = RD_BRANCH;
            hs_valid && !hart_active[h] && (hs_id == HART_ID_W'(h)):
               redir[h] = RD_START;
            fire && !squash && (sel == HART_ID_W'(h)):
               redir[h] = RD_SEQ;
            default:
               redir[h] = RD_NONE;
         endcase
      end
   end

   // Next PC per hart from its redirect source
   always_comb begin
      for (int h = 0; h < HART_NUM; h++) begin
         pc_nxt[h] = pcs[h];
         unique case (redir[h])
            RD_FLUSH:  pc_nxt[h] = flush_pc;
            RD_BRANCH: pc_nxt[h] = br_addr;
            RD_START:  pc_nxt[h] = hs_pc;
            RD_SEQ:    pc_nxt[h] = pcs[h] + ADDR_W'(4);
            default:   pc_nxt[h] = pcs[h];
         endcase
      end
   end

   // PC file and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int h = 0; h < HART_NUM; h++)
            pcs[h] <= RESET_PC;
         rr_ptr <= '0;
      end else begin
         for (int h = 0; h < HART_NUM; h++)
            pcs[h] <= pc_nxt[h];
         if (fire)
            rr_ptr <= (sel == LAST_HART) ? '0 : sel + 1'b1;
      end
   end

   // IF/ID register: bubble, hold under stall, or capture the fetch
   always_ff @(posedge clk) begin
      if (reset) begin
         if_pc      <= '0;
         if_insn    <= NOP_INSN;
         if_en      <= 1'b0;
         if_hart_id <= '0;
      end else if (do_bubble) begin
         if_insn    <= NOP_INSN;
         if_en      <= 1'b0;
         if_hart_id <= sel;
      end else if (do_load) begin
         if_pc      <= imem_addr;
         if_insn    <= imem_insn;
         if_en      <= 1'b1;
         if_hart_id <= sel;
      end
   end

endmodule

// File: tb/tb_mt_fetch_reg.sv
// Directed bench for mt_fetch_reg.
// Memory returns addr ^ KEY so each captured insn ties to its PC.
module tb_mt_fetch_reg;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  hart_active;
   logic        hs_valid;
   logic [1:0]  hs_id;
   logic [31:0] hs_pc;
   logic        br_taken;
   logic [1:0]  br_hart_id;
   logic [31:0] br_addr;
   logic        flush;
   logic [1:0]  flush_hart_id;
   logic [31:0] flush_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_insn;
   logic [31:0] if_pc;
   logic [31:0] if_insn;
   logic        if_en;
   logic [1:0]  if_hart_id;

   int n_chk  = 0;
   int n_pass = 0;

   mt_fetch_reg dut (
      .clk           (clk),
      .reset         (reset),
      .hart_active   (hart_active),
      .hs_valid      (hs_valid),
      .hs_id         (hs_id),
      .hs_pc         (hs_pc),
      .br_taken      (br_taken),
      .br_hart_id    (br_hart_id),
      .br_addr       (br_addr),
      .flush         (flush),
      .flush_hart_id (flush_hart_id),
      .flush_pc      (flush_pc),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdy      (imem_rdy),
      .imem_insn     (imem_insn),
      .if_pc         (if_pc),
      .if_insn       (if_insn),
      .if_en         (if_en),
      .if_hart_id    (if_hart_id)
   );

   always #5 clk = ~clk;

   assign imem_insn = imem_addr ^ KEY;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_if(input string tag, input logic en,
                            input logic [1:0] hid,
                            input logic [31:0] pc);
      check({tag, ".en"}, 32'(if_en), 32'(en));
      check({tag, ".hid"}, 32'(if_hart_id), 32'(hid));
      check({tag, ".pc"}, if_pc, pc);
      check({tag, ".insn"}, if_insn, en ? (pc ^ KEY) : NOP);
   endtask

   initial begin
      reset = 1'b1; hart_active = '0; stall = 1'b0; imem_rdy = 1'b1;
      hs_valid = 1'b0; hs_id = '0; hs_pc = '0;
      br_taken = 1'b0; br_hart_id = '0; br_addr = '0;
      flush = 1'b0; flush_hart_id = '0; flush_pc = '0;

      step(); step();
      expect_if("reset", 1'b0, 2'd0, 32'h0);
      check("reset.req", 32'(imem_req), 32'd0);
      reset = 1'b0;

      // load start PCs while harts idle
      hs_valid = 1'b1;
      hs_id = 2'd1; hs_pc = 32'h100; step();
      hs_id = 2'd2; hs_pc = 32'h200; step();
      hs_id = 2'd3; hs_pc = 32'h300; step();
      hs_valid = 1'b0;
      expect_if("idle", 1'b0, 2'd0, 32'h0);

      // all four harts round-robin
      hart_active = 4'hF;
      #1;
      check("rr.req", 32'(imem_req), 32'd1);
      check("rr.addr", imem_addr, 32'h0);
      step(); expect_if("rr0", 1'b1, 2'd0, 32'h000);
      step(); expect_if("rr1", 1'b1, 2'd1, 32'h100);
      step(); expect_if("rr2", 1'b1, 2'd2, 32'h200);
      step(); expect_if("rr3", 1'b1, 2'd3, 32'h300);
      step(); expect_if("rr4", 1'b1, 2'd0, 32'h004);

      // harts 0 and 2 only, memory not ready for two cycles
      hart_active = 4'b0101;
      step(); expect_if("alt0", 1'b1, 2'd2, 32'h204);
      step(); expect_if("alt1", 1'b1, 2'd0, 32'h008);
      imem_rdy = 1'b0;
      #1;
      check("nrdy.addr0", imem_addr, 32'h208);
      step(); expect_if("nrdy0", 1'b0, 2'd2, 32'h008);
      check("nrdy.addr1", imem_addr, 32'h208);
      step(); expect_if("nrdy1", 1'b0, 2'd2, 32'h008);
      imem_rdy = 1'b1;
      step(); expect_if("rdy0", 1'b1, 2'd2, 32'h208);
      step(); expect_if("rdy1", 1'b1, 2'd0, 32'h00C);

      // branch squash on hart 1, fetched and registered
      hart_active = 4'b0010;
      step(); expect_if("br.pre", 1'b1, 2'd1, 32'h104);
      br_taken = 1'b1; br_hart_id = 2'd1; br_addr = 32'h400;
      step(); expect_if("br.sq", 1'b0, 2'd1, 32'h104);
      br_taken = 1'b0;
      step(); expect_if("br.tgt", 1'b1, 2'd1, 32'h400);
      step(); expect_if("single", 1'b1, 2'd1, 32'h404);

      // start idle hart 3; start to active hart 2 ignored
      hs_valid = 1'b1; hs_id = 2'd3; hs_pc = 32'h800;
      step(); expect_if("hs3", 1'b1, 2'd1, 32'h408);
      hart_active = 4'b1110; hs_id = 2'd2; hs_pc = 32'hBAD0;
      step(); expect_if("hs2", 1'b1, 2'd2, 32'h20C);
      hs_valid = 1'b0;
      step(); expect_if("hs3.f", 1'b1, 2'd3, 32'h800);
      step(); expect_if("hs.h1", 1'b1, 2'd1, 32'h40C);
      step(); expect_if("hs2.f", 1'b1, 2'd2, 32'h210);
      step(); expect_if("hs3.n", 1'b1, 2'd3, 32'h804);

      // stall with flush h0 and branch h2, IF/ID holds hart 1
      hart_active = 4'hF;
      step(); expect_if("st.a", 1'b1, 2'd0, 32'h010);
      step(); expect_if("st.b", 1'b1, 2'd1, 32'h410);
      stall = 1'b1;
      flush = 1'b1; flush_hart_id = 2'd0; flush_pc = 32'h40;
      br_taken = 1'b1; br_hart_id = 2'd2; br_addr = 32'h900;
      #1;
      check("st.req", 32'(imem_req), 32'd0);
      step(); expect_if("st.hold", 1'b1, 2'd1, 32'h410);
      stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
      step(); expect_if("st.h2", 1'b1, 2'd2, 32'h214);
      step(); expect_if("st.h3", 1'b1, 2'd3, 32'h808);
      step(); expect_if("st.h0", 1'b1, 2'd0, 32'h040);

      // stall with flush of the hart held in IF/ID
      stall = 1'b1;
      flush = 1'b1; flush_hart_id = 2'd0; flush_pc = 32'hFFFF_FFFC;
      step(); expect_if("st.fl", 1'b0, 2'd1, 32'h040);
      stall = 1'b0; flush = 1'b0;

      // PC wrap at top of address space
      hart_active = 4'b0001;
      step(); expect_if("wrap0", 1'b1, 2'd0, 32'hFFFF_FFFC);
      step(); expect_if("wrap1", 1'b1, 2'd0, 32'h0);

      // no active hart
      hart_active = 4'b0000;
      #1;
      check("none.req", 32'(imem_req), 32'd0);
      step(); expect_if("none", 1'b0, 2'd1, 32'h0);

      // reset mid-stream
      hart_active = 4'hF;
      step();
      reset = 1'b1;
      step(); expect_if("rst2", 1'b0, 2'd0, 32'h0);
      reset = 1'b0;
      step(); expect_if("post0", 1'b1, 2'd0, 32'h0);
      step(); expect_if("post1", 1'b1, 2'd1, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
